sdram_port_arbiter: RTL and testbench
=====================================

Name: sdram_port_arbiter

Overview:
- Two-requester Avalon-MM arbiter in front of the single slave port of the new_sdram_controller_0 SDRAM controller inside cpuqsys.
- Requester 0 is the CPU data master; requester 1 is a DMA/LED-pattern engine.
- Round-robin grant with command hold while the slave stalls.
- Tracks outstanding pipelined reads so each returned readdata goes back to the requester that issued it.

Parameters:
- ADDR_W, 24, word address width toward the SDRAM controller slave.
- DATA_W, 32, data width; matches the 32-bit SDRAM dq bus.
- MAX_PEND, 8, maximum outstanding reads; power of two, at least 2.

Ports:
- clk_clk  in  1  system clock
- reset_reset  in  1  synchronous active-high reset
- m0_address / m1_address  in  ADDR_W  requester word address
- m0_read / m1_read  in  1  read request
- m0_write / m1_write  in  1  write request
- m0_writedata / m1_writedata  in  DATA_W  write data
- m0_byteenable / m1_byteenable  in  DATA_W/8  byte lanes
- m0_waitrequest / m1_waitrequest  out  1  low = command accepted this cycle
- m0_readdata / m1_readdata  out  DATA_W  returned data
- m0_readdatavalid / m1_readdatavalid  out  1  returned data valid
- s_address  out  ADDR_W  to controller
- s_read, s_write  out  1  to controller
- s_writedata  out  DATA_W  to controller
- s_byteenable  out  DATA_W/8  to controller
- s_waitrequest  in  1  controller stall
- s_readdata  in  DATA_W  controller read data
- s_readdatavalid  in  1  controller read data valid
- arb_error  out  1  sticky: readdatavalid arrived with no read pending

Behaviour:
- Reset values:
  - m*_waitrequest = 1; m*_readdatavalid = 0; m*_readdata = 0.
  - s_read = s_write = 0; s_address, s_writedata, s_byteenable = 0.
  - rr_ptr = 0; state = IDLE; tag FIFO empty; arb_error = 0.
- FSM states: IDLE, ISSUE.
- IDLE:
  - Eligible requester = read or write asserted. A read is eligible only if the tag FIFO is not full.
  - If both are eligible, the requester equal to rr_ptr wins.
  - The winner's command is registered onto s_* next cycle; go to ISSUE with gnt = winner.
  - If none is eligible, stay in IDLE with s_read = s_write = 0.
- ISSUE:
  - s_* held stable.
  - When s_waitrequest = 0: m{gnt}_waitrequest = 0 combinationally in that same cycle (acceptance).
  - On acceptance, a read pushes gnt into the tag FIFO; then s_read/s_write drop to 0, rr_ptr = ~gnt, next state IDLE.
  - While s_waitrequest = 1: stay in ISSUE.
- The non-granted requester's waitrequest is always 1. Outside an acceptance cycle, all m*_waitrequest = 1.
- Throughput: at most one command per 2 cycles. Minimum command latency is 2 cycles from the requester's assertion to waitrequest low.
- Requester asserting read and write simultaneously: treated as a write; the read is ignored.
- Read return:
  - On s_readdatavalid, pop the head tag.
  - Next cycle: m{tag}_readdata = s_readdata and m{tag}_readdatavalid = 1 for exactly one cycle. Fixed 1-cycle return latency.
  - The other requester's readdatavalid stays 0.
- Push and pop in the same cycle: occupancy is unchanged. Legal even when the FIFO is full.
- Full FIFO: reads are held off in IDLE. Writes still proceed.
- Pointers wrap modulo MAX_PEND.
- s_readdatavalid with the FIFO empty: no m* readdatavalid is produced; arb_error = 1 until reset.
- Reset mid-transfer:
  - Returns immediately to the reset state; the tag FIFO is flushed.
  - Data returning after reset raises arb_error. The system reset also resets the controller, so this is diagnostic only.

Optional Feature:
- Macro: SDRAM_PORT_ARBITER_STATS_EN.
- Defined:
  - Adds outputs stat_grant0 and stat_grant1 (32 bits each): count accepted commands per requester.
  - Adds stat_stall (32 bits): counts ISSUE cycles with s_waitrequest = 1.
  - All three clear on reset and saturate at 0xFFFFFFFF.
- Undefined: those ports and counters do not exist; behaviour is otherwise identical.

Decomposition:
- Package sdram_arb_pkg:
  - state enum {IDLE, ISSUE}
  - REQ_CPU = 1'b0, REQ_DMA = 1'b1
  - counter width constant STAT_W = 32
- Sub-module sdram_arb_tag_fifo: 1-bit-wide synchronous FIFO, depth MAX_PEND, with push, pop, full, empty and head outputs.

Test Plan:
- Single write: m0 writes addr 0x000010, data 0xDEADBEEF, be 0xF, s_waitrequest = 0 → s_write = 1 with those values next cycle; m0_waitrequest low in that cycle; rr_ptr = 1.
- Contention: both requesters read at the same cycle from reset → m0 is granted first, then m1. Controller returns 0x11111111 then 0x22222222 → m0 gets 0x11111111 and m1 gets 0x22222222, each one cycle after s_readdatavalid.
- Stall: s_waitrequest held high for 5 cycles during an m1 write → s_* stable for all 5 cycles; m1_waitrequest stays 1 until the cycle s_waitrequest falls; stat_stall = 5 (with SDRAM_PORT_ARBITER_STATS_EN).
- Full FIFO: m0 issues 8 reads with no data returned → the 9th read is held in IDLE. One s_readdatavalid frees a slot → the 9th read issues.
- Error: s_readdatavalid pulse with no read pending → no m* readdatavalid; arb_error = 1 and stays high until reset_reset.
- Reset mid-ISSUE: assert reset_reset while s_read = 1 → next cycle s_read = 0, both m*_waitrequest = 1, FIFO empty.

Source files
------------

// File: rtl/sdram_arb_pkg.sv
// Shared types and constants for the SDRAM port arbiter.
//   arb_state_e : arbiter FSM state (IDLE, ISSUE)
//   REQ_CPU/DMA : requester identifiers used as grant values and read-return tags
//   STAT_W      : width of the optional statistics counters
//   sat_inc     : saturating increment for the statistics counters
package sdram_arb_pkg;

  typedef enum logic [0:0] {
    IDLE  = 1'b0,
    ISSUE = 1'b1
  } arb_state_e;

  localparam logic REQ_CPU = 1'b0;
  localparam logic REQ_DMA = 1'b1;

  localparam int unsigned STAT_W = 32;

  function automatic logic [STAT_W-1:0] sat_inc(input logic [STAT_W-1:0] v);
    return (v == '1) ? v : v + STAT_W'(1);
  endfunction

endpackage

// File: rtl/sdram_arb_tag_fifo.sv
// 1-bit-wide synchronous FIFO holding the requester tag of each outstanding read.
//   clk_i   : clock
//   rst_i   : synchronous active-high reset, flushes the FIFO
//   push_i  : write data_i (ignored when full unless popping in the same cycle)
//   data_i  : tag to store
//   pop_i   : discard the head entry (ignored when empty)
//   full_o  : Depth entries stored
//   empty_o : no entries stored
//   head_o  : oldest stored tag
// Depth must be a power of two so the pointers wrap naturally.
module sdram_arb_tag_fifo #(
  parameter int unsigned Depth = 8
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic push_i,
  input  logic data_i,
  input  logic pop_i,
  output logic full_o,
  output logic empty_o,
  output logic head_o
);

  localparam int unsigned PtrW = $clog2(Depth);
  localparam int unsigned CntW = PtrW + 1;

  logic [Depth-1:0] mem_q;
  logic [PtrW-1:0]  wr_ptr_q, rd_ptr_q;
  logic [CntW-1:0]  count_q;
  logic             do_push, do_pop;

  assign full_o  = (count_q == CntW'(Depth));
  assign empty_o = (count_q == '0);
  assign head_o  = mem_q[rd_ptr_q];

  // A pop frees the head slot in the same cycle, so push-while-full is legal with a pop.
  assign do_push = push_i & (~full_o | pop_i);
  assign do_pop  = pop_i & ~empty_o;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      mem_q    <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_push) begin
        mem_q[wr_ptr_q] <= data_i;
        wr_ptr_q        <= wr_ptr_q + PtrW'(1);
      end
      if (do_pop) begin
        rd_ptr_q <= rd_ptr_q + PtrW'(1);
      end
      unique case ({do_push, do_pop})
        2'b10:   count_q <= count_q + CntW'(1);
        2'b01:   count_q <= count_q - CntW'(1);
        default: count_q <= count_q;
      endcase
    end
  end

endmodule

// File: rtl/sdram_port_arbiter.sv
// Two-requester Avalon-MM arbiter in front of the SDRAM controller slave port.
// Requester 0 is the CPU data master, requester 1 the DMA/LED-pattern engine.
//   clk_clk, reset_reset      : clock, synchronous active-high reset
//   m0_*/m1_* (in)            : requester address/read/write/writedata/byteenable
//   m0_*/m1_* (out)           : waitrequest (low = accepted), readdata, readdatavalid
//   s_* (out)                 : registered command toward the controller
//   s_waitrequest/readdata/readdatavalid (in) : controller responses
//   arb_error                 : sticky, read data returned with no read pending
// Optional: define SDRAM_PORT_ARBITER_STATS_EN to add stat_grant0, stat_grant1
// (accepted commands per requester) and stat_stall (stalled ISSUE cycles).
module sdram_port_arbiter
  import sdram_arb_pkg::*;
#(
  parameter int unsigned ADDR_W   = 24,
  parameter int unsigned DATA_W   = 32,
  parameter int unsigned MAX_PEND = 8
) (
  input  logic                  clk_clk,
  input  logic                  reset_reset,
  input  logic [ADDR_W-1:0]     m0_address,
  input  logic                  m0_read,
  input  logic                  m0_write,
  input  logic [DATA_W-1:0]     m0_writedata,
  input  logic [DATA_W/8-1:0]   m0_byteenable,
  output logic                  m0_waitrequest,
  output logic [DATA_W-1:0]     m0_readdata,
  output logic                  m0_readdatavalid,
  input  logic [ADDR_W-1:0]     m1_address,
  input  logic                  m1_read,
  input  logic                  m1_write,
  input  logic [DATA_W-1:0]     m1_writedata,
  input  logic [DATA_W/8-1:0]   m1_byteenable,
  output logic                  m1_waitrequest,
  output logic [DATA_W-1:0]     m1_readdata,
  output logic                  m1_readdatavalid,
  output logic [ADDR_W-1:0]     s_address,
  output logic                  s_read,
  output logic                  s_write,
  output logic [DATA_W-1:0]     s_writedata,
  output logic [DATA_W/8-1:0]   s_byteenable,
  input  logic                  s_waitrequest,
  input  logic [DATA_W-1:0]     s_readdata,
  input  logic                  s_readdatavalid,
  output logic                  arb_error
`ifdef SDRAM_PORT_ARBITER_STATS_EN
  ,
  output logic [STAT_W-1:0]     stat_grant0,
  output logic [STAT_W-1:0]     stat_grant1,
  output logic [STAT_W-1:0]     stat_stall
`endif
);

  arb_state_e            state_q;
  logic                  gnt_q, rr_ptr_q;
  logic [ADDR_W-1:0]     s_address_q;
  logic                  s_read_q, s_write_q;
  logic [DATA_W-1:0]     s_writedata_q;
  logic [DATA_W/8-1:0]   s_byteenable_q;
  logic [DATA_W-1:0]     m0_readdata_q, m1_readdata_q;
  logic                  m0_rdv_q, m1_rdv_q;
  logic                  arb_error_q;

  logic fifo_full, fifo_empty, fifo_head;
  logic elig0, elig1, win;
  logic accept, push, rdv_ok;

  logic [ADDR_W-1:0]     sel_address;
  logic                  sel_write;
  logic [DATA_W-1:0]     sel_writedata;
  logic [DATA_W/8-1:0]   sel_byteenable;

  // A write always qualifies; a read (or read+write treated as write) needs a free tag slot.
  assign elig0 = m0_write | (m0_read & ~fifo_full);
  assign elig1 = m1_write | (m1_read & ~fifo_full);
  assign win   = (elig0 & elig1) ? rr_ptr_q : elig1;

  assign sel_address    = win ? m1_address    : m0_address;
  assign sel_write      = win ? m1_write      : m0_write;
  assign sel_writedata  = win ? m1_writedata  : m0_writedata;
  assign sel_byteenable = win ? m1_byteenable : m0_byteenable;

  assign accept = (state_q == ISSUE) & ~s_waitrequest;
  assign push   = accept & s_read_q;
  // Returned data with nothing outstanding is dropped and flagged.
  assign rdv_ok = s_readdatavalid & ~fifo_empty;

  assign m0_waitrequest = ~(accept & (gnt_q == REQ_CPU));
  assign m1_waitrequest = ~(accept & (gnt_q == REQ_DMA));

  sdram_arb_tag_fifo #(
    .Depth (MAX_PEND)
  ) u_tag_fifo (
    .clk_i   (clk_clk),
    .rst_i   (reset_reset),
    .push_i  (push),
    .data_i  (gnt_q),
    .pop_i   (rdv_ok),
    .full_o  (fifo_full),
    .empty_o (fifo_empty),
    .head_o  (fifo_head)
  );

  always_ff @(posedge clk_clk) begin
    if (reset_reset) begin
      state_q        <= IDLE;
      gnt_q          <= REQ_CPU;
      rr_ptr_q       <= REQ_CPU;
      s_address_q    <= '0;
      s_read_q       <= 1'b0;
      s_write_q      <= 1'b0;
      s_writedata_q  <= '0;
      s_byteenable_q <= '0;
      m0_readdata_q  <= '0;
      m1_readdata_q  <= '0;
      m0_rdv_q       <= 1'b0;
      m1_rdv_q       <= 1'b0;
      arb_error_q    <= 1'b0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (elig0 | elig1) begin
            s_address_q    <= sel_address;
            s_write_q      <= sel_write;
            s_read_q       <= ~sel_write;
            s_writedata_q  <= sel_writedata;
            s_byteenable_q <= sel_byteenable;
            gnt_q          <= win;
            state_q        <= ISSUE;
          end
        end
        ISSUE: begin
          if (!s_waitrequest) begin
            s_read_q  <= 1'b0;
            s_write_q <= 1'b0;
            rr_ptr_q  <= ~gnt_q;
            state_q   <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase

      m0_rdv_q <= rdv_ok & (fifo_head == REQ_CPU);
      m1_rdv_q <= rdv_ok & (fifo_head == REQ_DMA);
      if (rdv_ok && fifo_head == REQ_CPU) m0_readdata_q <= s_readdata;
      if (rdv_ok && fifo_head == REQ_DMA) m1_readdata_q <= s_readdata;
      if (s_readdatavalid && fifo_empty) arb_error_q <= 1'b1;
    end
  end

  assign s_address        = s_address_q;
  assign s_read           = s_read_q;
  assign s_write          = s_write_q;
  assign s_writedata      = s_writedata_q;
  assign s_byteenable     = s_byteenable_q;
  assign m0_readdata      = m0_readdata_q;
  assign m1_readdata      = m1_readdata_q;
  assign m0_readdatavalid = m0_rdv_q;
  assign m1_readdatavalid = m1_rdv_q;
  assign arb_error        = arb_error_q;

`ifdef SDRAM_PORT_ARBITER_STATS_EN
  logic [STAT_W-1:0] stat_grant0_q, stat_grant1_q, stat_stall_q;

  always_ff @(posedge clk_clk) begin
    if (reset_reset) begin
      stat_grant0_q <= '0;
      stat_grant1_q <= '0;
      stat_stall_q  <= '0;
    end else begin
      if (accept && gnt_q == REQ_CPU) stat_grant0_q <= sat_inc(stat_grant0_q);
      if (accept && gnt_q == REQ_DMA) stat_grant1_q <= sat_inc(stat_grant1_q);
      if (state_q == ISSUE && s_waitrequest) stat_stall_q <= sat_inc(stat_stall_q);
    end
  end

  assign stat_grant0 = stat_grant0_q;
  assign stat_grant1 = stat_grant1_q;
  assign stat_stall  = stat_stall_q;
`endif

endmodule

// File: tb/tb_sdram_port_arbiter.sv
// Self-checking bench for sdram_port_arbiter. Read returns are scoreboarded:
// {tag, data} is queued when s_readdatavalid is driven and popped when an
// m*_readdatavalid appears.
module tb_sdram_port_arbiter;

  localparam int unsigned ADDR_W   = 24;
  localparam int unsigned DATA_W   = 32;
  localparam int unsigned MAX_PEND = 8;
  localparam int unsigned BE_W     = DATA_W / 8;

  logic              clk_clk = 1'b0;
  logic              reset_reset;
  logic [ADDR_W-1:0] m0_address, m1_address;
  logic              m0_read, m1_read, m0_write, m1_write;
  logic [DATA_W-1:0] m0_writedata, m1_writedata;
  logic [BE_W-1:0]   m0_byteenable, m1_byteenable;
  logic              m0_waitrequest, m1_waitrequest;
  logic [DATA_W-1:0] m0_readdata, m1_readdata;
  logic              m0_readdatavalid, m1_readdatavalid;
  logic [ADDR_W-1:0] s_address;
  logic              s_read, s_write;
  logic [DATA_W-1:0] s_writedata;
  logic [BE_W-1:0]   s_byteenable;
  logic              s_waitrequest;
  logic [DATA_W-1:0] s_readdata;
  logic              s_readdatavalid;
  logic              arb_error;
`ifdef SDRAM_PORT_ARBITER_STATS_EN
  logic [31:0]       stat_grant0, stat_grant1, stat_stall;
`endif

  int checks   = 0;
  int failures = 0;
  logic [DATA_W:0] sb_q[$];

  always #5 clk_clk = ~clk_clk;

  sdram_port_arbiter #(
    .ADDR_W   (ADDR_W),
    .DATA_W   (DATA_W),
    .MAX_PEND (MAX_PEND)
  ) dut (
    .clk_clk          (clk_clk),
    .reset_reset      (reset_reset),
    .m0_address       (m0_address),
    .m0_read          (m0_read),
    .m0_write         (m0_write),
    .m0_writedata     (m0_writedata),
    .m0_byteenable    (m0_byteenable),
    .m0_waitrequest   (m0_waitrequest),
    .m0_readdata      (m0_readdata),
    .m0_readdatavalid (m0_readdatavalid),
    .m1_address       (m1_address),
    .m1_read          (m1_read),
    .m1_write         (m1_write),
    .m1_writedata     (m1_writedata),
    .m1_byteenable    (m1_byteenable),
    .m1_waitrequest   (m1_waitrequest),
    .m1_readdata      (m1_readdata),
    .m1_readdatavalid (m1_readdatavalid),
    .s_address        (s_address),
    .s_read           (s_read),
    .s_write          (s_write),
    .s_writedata      (s_writedata),
    .s_byteenable     (s_byteenable),
    .s_waitrequest    (s_waitrequest),
    .s_readdata       (s_readdata),
    .s_readdatavalid  (s_readdatavalid),
    .arb_error        (arb_error)
`ifdef SDRAM_PORT_ARBITER_STATS_EN
    ,
    .stat_grant0      (stat_grant0),
    .stat_grant1      (stat_grant1),
    .stat_stall       (stat_stall)
`endif
  );

  // Read-return scoreboard monitor.
  always @(negedge clk_clk) begin : rd_mon
    logic [DATA_W:0] exp_e;
    logic [DATA_W:0] obs_e;
    if (m0_readdatavalid || m1_readdatavalid) begin
      checks++;
      obs_e = {m1_readdatavalid, m1_readdatavalid ? m1_readdata : m0_readdata};
      if (m0_readdatavalid && m1_readdatavalid) begin
        failures++;
        $display("FAIL rdv_both: both readdatavalid high, required one");
      end else if (sb_q.size() == 0) begin
        failures++;
        $display("FAIL rdv_unexpected: tag/data %h returned, required none", obs_e);
      end else begin
        exp_e = sb_q.pop_front();
        if (obs_e !== exp_e) begin
          failures++;
          $display("FAIL rdv_data: got tag/data %h, required %h", obs_e, exp_e);
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  task automatic cyc();
    @(posedge clk_clk);
    #1;
  endtask

  task automatic idle_inputs();
    m0_address = '0; m0_read = 0; m0_write = 0; m0_writedata = '0; m0_byteenable = '0;
    m1_address = '0; m1_read = 0; m1_write = 0; m1_writedata = '0; m1_byteenable = '0;
    s_waitrequest = 0; s_readdata = '0; s_readdatavalid = 0;
  endtask

  task automatic apply_reset();
    reset_reset = 1;
    idle_inputs();
    repeat (2) @(posedge clk_clk);
    #1 reset_reset = 0;
  endtask

  task automatic test_reset();
    reset_reset = 1;
    idle_inputs();
    cyc();
    @(negedge clk_clk);
    checks++;
    if ({m0_waitrequest, m1_waitrequest} !== 2'b11) begin
      failures++; $display("FAIL reset_wait: got %b, required 11", {m0_waitrequest, m1_waitrequest});
    end
    checks++;
    if ({m0_readdatavalid, m1_readdatavalid, m0_readdata, m1_readdata} !== '0) begin
      failures++; $display("FAIL reset_rd: readdata/valid not zero");
    end
    checks++;
    if ({s_read, s_write, s_address, s_writedata, s_byteenable} !== '0) begin
      failures++; $display("FAIL reset_s: slave command outputs not zero");
    end
    checks++;
    if (arb_error !== 1'b0) begin
      failures++; $display("FAIL reset_err: got %b, required 0", arb_error);
    end
    cyc();
    reset_reset = 0;
  endtask

  task automatic test_single_write();
    apply_reset();
    m0_address = 24'h000010; m0_writedata = 32'hDEADBEEF; m0_byteenable = 4'hF; m0_write = 1;
    @(negedge clk_clk);
    checks++;
    if (m0_waitrequest !== 1'b1) begin
      failures++; $display("FAIL sw_latency: waitrequest %b in first cycle, required 1", m0_waitrequest);
    end
    cyc();
    @(negedge clk_clk);
    checks++;
    if ({s_write, s_read, s_address, s_writedata, s_byteenable} !==
        {1'b1, 1'b0, 24'h000010, 32'hDEADBEEF, 4'hF}) begin
      failures++;
      $display("FAIL sw_cmd: got w%b r%b a%h d%h be%h, required w1 r0 a000010 ddeadbeef bef",
               s_write, s_read, s_address, s_writedata, s_byteenable);
    end
    checks++;
    if ({m0_waitrequest, m1_waitrequest} !== 2'b01) begin
      failures++; $display("FAIL sw_accept: got %b, required 01", {m0_waitrequest, m1_waitrequest});
    end
    cyc();
    // New commands on both ports; rr pointer now favours m1.
    m0_address = 24'h000100; m0_writedata = 32'h0000_0A0A; m0_write = 1;
    m1_address = 24'h000200; m1_writedata = 32'h0000_0B0B; m1_byteenable = 4'h3; m1_write = 1;
    @(negedge clk_clk);
    checks++;
    if ({s_write, m0_waitrequest, m1_waitrequest} !== 3'b011) begin
      failures++; $display("FAIL sw_drop: got %b, required 011", {s_write, m0_waitrequest, m1_waitrequest});
    end
    cyc();
    @(negedge clk_clk);
    checks++;
    if ({s_address, m0_waitrequest, m1_waitrequest} !== {24'h000200, 2'b10}) begin
      failures++; $display("FAIL sw_rr_m1: got a%h w%b, required a000200 w10",
                           s_address, {m0_waitrequest, m1_waitrequest});
    end
    cyc();
    m1_write = 0;
    cyc();
    @(negedge clk_clk);
    checks++;
    if ({s_address, m0_waitrequest, m1_waitrequest} !== {24'h000100, 2'b01}) begin
      failures++; $display("FAIL sw_rr_m0: got a%h w%b, required a000100 w01",
                           s_address, {m0_waitrequest, m1_waitrequest});
    end
    cyc();
    m0_write = 0;
  endtask

  task automatic test_contention();
    apply_reset();
    m0_address = 24'h000040; m1_address = 24'h000080; m0_read = 1; m1_read = 1;
    cyc();
    @(negedge clk_clk);
    checks++;
    if ({s_read, s_address, m0_waitrequest, m1_waitrequest} !== {1'b1, 24'h000040, 2'b01}) begin
      failures++; $display("FAIL ct_first: got r%b a%h w%b, required r1 a000040 w01",
                           s_read, s_address, {m0_waitrequest, m1_waitrequest});
    end
    cyc();
    m0_read = 0;
    @(negedge clk_clk);
    checks++;
    if (s_read !== 1'b0) begin
      failures++; $display("FAIL ct_gap: s_read %b, required 0", s_read);
    end
    cyc();
    @(negedge clk_clk);
    checks++;
    if ({s_read, s_address, m0_waitrequest, m1_waitrequest} !== {1'b1, 24'h000080, 2'b10}) begin
      failures++; $display("FAIL ct_second: got r%b a%h w%b, required r1 a000080 w10",
                           s_read, s_address, {m0_waitrequest, m1_waitrequest});
    end
    cyc();
    m1_read = 0;
    s_readdatavalid = 1; s_readdata = 32'h11111111; sb_q.push_back({1'b0, 32'h11111111});
    cyc();
    s_readdata = 32'h22222222; sb_q.push_back({1'b1, 32'h22222222});
    @(negedge clk_clk);
    checks++;
    if ({m0_readdatavalid, m1_readdatavalid} !== 2'b10) begin
      failures++; $display("FAIL ct_ret0: got %b, required 10", {m0_readdatavalid, m1_readdatavalid});
    end
    cyc();
    s_readdatavalid = 0;
    @(negedge clk_clk);
    checks++;
    if ({m0_readdatavalid, m1_readdatavalid} !== 2'b01) begin
      failures++; $display("FAIL ct_ret1: got %b, required 01", {m0_readdatavalid, m1_readdatavalid});
    end
    cyc();
    cyc();
    checks++;
    if (sb_q.size() != 0) begin
      failures++; $display("FAIL ct_drain: %0d returns outstanding, required 0", sb_q.size());
    end
  endtask

  task automatic test_stall();
    apply_reset();
    // Read and write together: must go out as a write.
    m1_address = 24'h00ABCD; m1_writedata = 32'hCAFEF00D; m1_byteenable = 4'h5;
    m1_write = 1; m1_read = 1; s_waitrequest = 1;
    cyc();
    for (int i = 0; i < 5; i++) begin
      @(negedge clk_clk);
      checks++;
      if ({s_write, s_read, s_address, s_writedata, s_byteenable, m0_waitrequest, m1_waitrequest} !==
          {1'b1, 1'b0, 24'h00ABCD, 32'hCAFEF00D, 4'h5, 2'b11}) begin
        failures++; $display("FAIL st_hold%0d: w%b r%b a%h d%h be%h wr%b", i, s_write, s_read,
                             s_address, s_writedata, s_byteenable, {m0_waitrequest, m1_waitrequest});
      end
      cyc();
    end
    s_waitrequest = 0;
    @(negedge clk_clk);
    checks++;
    if ({m0_waitrequest, m1_waitrequest} !== 2'b10) begin
      failures++; $display("FAIL st_accept: got %b, required 10", {m0_waitrequest, m1_waitrequest});
    end
    cyc();
    m1_write = 0; m1_read = 0;
    @(negedge clk_clk);
    checks++;
    if (s_write !== 1'b0) begin
      failures++; $display("FAIL st_drop: s_write %b, required 0", s_write);
    end
`ifdef SDRAM_PORT_ARBITER_STATS_EN
    checks++;
    if ({stat_stall, stat_grant1, stat_grant0} !== {32'd5, 32'd1, 32'd0}) begin
      failures++; $display("FAIL st_stats: stall %0d g1 %0d g0 %0d, required 5 1 0",
                           stat_stall, stat_grant1, stat_grant0);
    end
`endif
    // The ignored read must not have left a tag behind.
    s_readdatavalid = 1; s_readdata = 32'h0BAD0BAD;
    cyc();
    s_readdatavalid = 0;
    @(negedge clk_clk);
    checks++;
    if (arb_error !== 1'b1) begin
      failures++; $display("FAIL st_notag: arb_error %b, required 1", arb_error);
    end
  endtask

  task automatic test_full_fifo();
    int n;
    apply_reset();
    m0_address = 24'h000300; m0_read = 1;
    n = 0;
    for (int c = 0; c < 40 && n < MAX_PEND; c++) begin
      @(negedge clk_clk);
      if (!m0_waitrequest) n++;
      cyc();
    end
    checks++;
    if (n != MAX_PEND) begin
      failures++; $display("FAIL ff_fill: accepted %0d reads, required %0d", n, MAX_PEND);
    end
    for (int i = 0; i < 3; i++) begin
      @(negedge clk_clk);
      checks++;
      if ({s_read, m0_waitrequest} !== 2'b01) begin
        failures++; $display("FAIL ff_hold%0d: r%b wr%b, required r0 wr1", i, s_read, m0_waitrequest);
      end
      cyc();
    end
    // Writes still proceed while reads are held off.
    m1_address = 24'h000777; m1_write = 1;
    cyc();
    @(negedge clk_clk);
    checks++;
    if ({s_write, s_read, m1_waitrequest, m0_waitrequest} !== 4'b1001) begin
      failures++; $display("FAIL ff_write: got %b, required 1001",
                           {s_write, s_read, m1_waitrequest, m0_waitrequest});
    end
    cyc();
    m1_write = 0;
    s_readdatavalid = 1; s_readdata = 32'h5555AAAA; sb_q.push_back({1'b0, 32'h5555AAAA});
    cyc();
    s_readdatavalid = 0;
    @(negedge clk_clk);
    checks++;
    if (s_read !== 1'b0) begin
      failures++; $display("FAIL ff_popedge: s_read %b, required 0", s_read);
    end
    cyc();
    @(negedge clk_clk);
    checks++;
    if ({s_read, s_address, m0_waitrequest} !== {1'b1, 24'h000300, 1'b0}) begin
      failures++; $display("FAIL ff_ninth: r%b a%h wr%b, required r1 a000300 wr0",
                           s_read, s_address, m0_waitrequest);
    end
    cyc();
    m0_read = 0;
    for (int i = 0; i < MAX_PEND; i++) begin
      s_readdatavalid = 1;
      s_readdata = 32'hA0000000 + i;
      sb_q.push_back({1'b0, 32'hA0000000 + i});
      cyc();
    end
    s_readdatavalid = 0;
    cyc();
    cyc();
    checks++;
    if (sb_q.size() != 0 || arb_error !== 1'b0) begin
      failures++; $display("FAIL ff_drain: %0d outstanding err %b, required 0 0", sb_q.size(), arb_error);
    end
  endtask

  task automatic test_error();
    apply_reset();
    @(negedge clk_clk);
    checks++;
    if (arb_error !== 1'b0) begin
      failures++; $display("FAIL er_pre: arb_error %b, required 0", arb_error);
    end
    s_readdatavalid = 1; s_readdata = 32'h12345678;
    cyc();
    s_readdatavalid = 0;
    @(negedge clk_clk);
    checks++;
    if ({m0_readdatavalid, m1_readdatavalid, arb_error} !== 3'b001) begin
      failures++; $display("FAIL er_set: got %b, required 001",
                           {m0_readdatavalid, m1_readdatavalid, arb_error});
    end
    repeat (3) cyc();
    checks++;
    if (arb_error !== 1'b1) begin
      failures++; $display("FAIL er_sticky: arb_error %b, required 1", arb_error);
    end
    apply_reset();
    @(negedge clk_clk);
    checks++;
    if (arb_error !== 1'b0) begin
      failures++; $display("FAIL er_clear: arb_error %b, required 0", arb_error);
    end
  endtask

  task automatic test_reset_mid_issue();
    apply_reset();
    m0_address = 24'h000900; m0_read = 1;
    cyc();
    cyc();
    // First read accepted; second read now stalls in ISSUE.
    s_waitrequest = 1;
    cyc();
    @(negedge clk_clk);
    checks++;
    if ({s_read, m0_waitrequest} !== 2'b11) begin
      failures++; $display("FAIL rm_issue: r%b wr%b, required r1 wr1", s_read, m0_waitrequest);
    end
    reset_reset = 1; m0_read = 0;
    cyc();
    reset_reset = 0; s_waitrequest = 0;
    @(negedge clk_clk);
    checks++;
    if ({s_read, m0_waitrequest, m1_waitrequest} !== 3'b011) begin
      failures++; $display("FAIL rm_state: got %b, required 011", {s_read, m0_waitrequest, m1_waitrequest});
    end
    cyc();
    // The tag of the accepted read was flushed: its data now counts as an error.
    s_readdatavalid = 1; s_readdata = 32'h99999999;
    cyc();
    s_readdatavalid = 0;
    @(negedge clk_clk);
    checks++;
    if ({m0_readdatavalid, arb_error} !== 2'b01) begin
      failures++; $display("FAIL rm_flush: got %b, required 01", {m0_readdatavalid, arb_error});
    end
    cyc();
  endtask

  initial begin
    test_reset();
    test_single_write();
    test_contention();
    test_stall();
    test_full_fifo();
    test_error();
    test_reset_mid_issue();
    checks++;
    if (sb_q.size() != 0) begin
      failures++; $display("FAIL sb_final: %0d returns never seen, required 0", sb_q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
